// File: rtl/vga_frame_monitor_if.sv
// vga_frame_monitor_if: RGB444 pixel stream with active-low HS/VS from the character generator
interface vga_frame_monitor_if;
  logic [3:0] r, g, b;
  logic       hs, vs;
  modport master (output r, g, b, hs, vs);
  modport slave  (input  r, g, b, hs, vs);
endinterface

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: recovers raster position from sync edges, checks 640x480@60 timing, checksums frames
module vga_frame_monitor #(
  parameter int unsigned CLK_FACTOR_25M = 4,
  parameter int unsigned H_TOTAL        = 800,
  parameter int unsigned H_SYNC         = 96,
  parameter int unsigned H_ACT_START    = 144,
  parameter int unsigned H_VISIBLE      = 640,
  parameter int unsigned V_TOTAL        = 525,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_ACT_START    = 35,
  parameter int unsigned V_VISIBLE      = 480
) (
  input  logic               clk_i,
  input  logic               arstn_i,
  vga_frame_monitor_if.slave vga,
  input  logic               err_clr_i,
  output logic               locked_o,
  output logic               frame_done_o,
  output logic [23:0]        frame_sum_o,
  output logic [15:0]        frame_cnt_o,
  output logic               err_o,
  output logic [7:0]         err_cnt_o
);
  typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_e;
  localparam logic [7:0]  PH_LAST = 8'(CLK_FACTOR_25M - 1);
  localparam logic [15:0] HPER = 16'(H_TOTAL * CLK_FACTOR_25M);
  localparam logic [15:0] HLOW = 16'(H_SYNC * CLK_FACTOR_25M);
  localparam logic [15:0] VTOT = 16'(V_TOTAL);
  localparam logic [15:0] VSW  = 16'(V_SYNC);
  localparam logic [15:0] HA0  = 16'(H_ACT_START);
  localparam logic [15:0] HA1  = 16'(H_ACT_START + H_VISIBLE);
  localparam logic [15:0] VA0  = 16'(V_ACT_START);
  localparam logic [15:0] VA1  = 16'(V_ACT_START + V_VISIBLE);
  state_e      state_q, state_d;
  logic        hs_q, vs_q, arm_q, arm_d, ok_q, ok_d, locked_q, locked_d, done_q, done_d, err_q, err_d;
  logic [7:0]  phase_q, phase_d, phase_e, err_cnt_q, err_cnt_d, err_cnt_b;
  logic [15:0] px_q, px_d, px_e, line_q, line_d, hper_q, hper_d, hlow_q, hlow_d;
  logic [15:0] nlines_q, nlines_d, vsw_q, vsw_d, frame_cnt_q, frame_cnt_d;
  logic [23:0] sum_q, sum_d, frame_sum_q, frame_sum_d;
  logic        hs_fall, hs_rise, vs_fall, vs_rise, strobe, vis, fail;
  function automatic logic [15:0] inc16(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction
  always_comb begin
    hs_fall     = hs_q & ~vga.hs;
    hs_rise     = ~hs_q & vga.hs;
    vs_fall     = vs_q & ~vga.vs;
    vs_rise     = ~vs_q & vga.vs;
    phase_e     = hs_fall ? 8'd0 : phase_q;
    strobe      = phase_e == PH_LAST;
    phase_d     = strobe ? 8'd0 : phase_e + 8'd1;
    px_e        = hs_fall ? 16'd0 : px_q;
    px_d        = strobe ? inc16(px_e) : px_e;
    line_d      = hs_fall ? ((arm_q | vs_fall) ? 16'd0 : inc16(line_q)) : line_q;
    arm_d       = ~hs_fall & (arm_q | vs_fall);
    vis         = px_e >= HA0 && px_e < HA1 && line_d >= VA0 && line_d < VA1;
    sum_d       = vs_fall ? 24'd0 : sum_q + ((strobe & vis) ? {12'd0, vga.r, vga.g, vga.b} : 24'd0);
    hper_d      = hs_fall ? 16'd1 : inc16(hper_q);
    hlow_d      = hs_fall ? 16'd1 : ~vga.hs ? inc16(hlow_q) : hlow_q;
    nlines_d    = vs_fall ? {15'd0, hs_fall} : hs_fall ? inc16(nlines_q) : nlines_q;
    vsw_d       = vs_fall ? {15'd0, hs_fall} : (hs_fall & ~vga.vs) ? inc16(vsw_q) : vsw_q;
    // a missing HS fall shows up as the period counter running past the nominal line length
    fail        = (hs_fall ? hper_q != HPER : hper_q > HPER) | (hs_rise & (hlow_q != HLOW)) |
                  (vs_fall & (nlines_q != VTOT)) | (vs_rise & (vsw_q != VSW));
    err_cnt_b   = err_clr_i ? 8'd0 : err_cnt_q;
    state_d     = state_q;
    ok_d        = ok_q;
    done_d      = 1'b0;
    err_d       = err_q & ~err_clr_i;
    err_cnt_d   = err_cnt_b;
    frame_sum_d = frame_sum_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      SEARCH: begin
        state_d = vs_fall ? TRAIN : SEARCH;
        ok_d    = ok_q | vs_fall;
      end
      TRAIN: begin
        state_d = (vs_fall & ok_q & ~fail) ? LOCKED : TRAIN;
        ok_d    = vs_fall | (ok_q & ~fail);
      end
      LOCKED: begin
        state_d     = fail ? SEARCH : LOCKED;
        err_d       = fail | err_d;
        err_cnt_d   = (fail & ~&err_cnt_b) ? err_cnt_b + 8'd1 : err_cnt_b;
        done_d      = vs_fall & ~fail;
        frame_sum_d = done_d ? sum_q : frame_sum_q;
        frame_cnt_d = done_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
      end
      default: state_d = SEARCH;
    endcase
    locked_d = state_d == LOCKED;
  end
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) begin
      state_q     <= SEARCH;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      arm_q       <= 1'b0;
      ok_q        <= 1'b0;
      locked_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      phase_q     <= '0;
      err_cnt_q   <= '0;
      px_q        <= '0;
      line_q      <= '0;
      hper_q      <= '0;
      hlow_q      <= '0;
      nlines_q    <= '0;
      vsw_q       <= '0;
      frame_cnt_q <= '0;
      sum_q       <= '0;
      frame_sum_q <= '0;
    end else begin
      state_q     <= state_d;
      hs_q        <= vga.hs;
      vs_q        <= vga.vs;
      arm_q       <= arm_d;
      ok_q        <= ok_d;
      locked_q    <= locked_d;
      done_q      <= done_d;
      err_q       <= err_d;
      phase_q     <= phase_d;
      err_cnt_q   <= err_cnt_d;
      px_q        <= px_d;
      line_q      <= line_d;
      hper_q      <= hper_d;
      hlow_q      <= hlow_d;
      nlines_q    <= nlines_d;
      vsw_q       <= vsw_d;
      frame_cnt_q <= frame_cnt_d;
      sum_q       <= sum_d;
      frame_sum_q <= frame_sum_d;
    end
  assign locked_o     = locked_q;
  assign frame_done_o = done_q;
  assign frame_sum_o  = frame_sum_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign err_o        = err_q;
  assign err_cnt_o    = err_cnt_q;
endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor: frame-level table plus random frames against a pixel-array checksum model
module tb_vga_frame_monitor;
  localparam int CF = 2, HT = 20, HS = 3, HA = 5, HV = 10, VT = 12, VS = 2, VA = 3, VV = 6;
  typedef enum int {K_WHITE, K_BLANK, K_DOT, K_EARLY, K_RAND, K_LONG, K_VSW} kind_e;
  typedef struct {
    kind_e kind;
    int    clr_line;
    logic  locked, done, err;
    int    cnt, ec;
  } row_t;
  logic clk = 1'b0, arstn = 1'b0, err_clr = 1'b0;
  logic locked, done, err;
  logic [23:0] fsum;
  logic [15:0] fcnt;
  logic [7:0]  ecnt;
  int checks = 0, errors = 0, n_done = 0, exp_ndone = 0;
  logic [23:0] prev_sum = '0, exp_fsum = '0;
  logic [11:0] pix [VT][HT];
  row_t rows [14];
  vga_frame_monitor_if vif();
  vga_frame_monitor #(
    .CLK_FACTOR_25M(CF), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HA), .H_VISIBLE(HV),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VA), .V_VISIBLE(VV)
  ) dut (
    .clk_i(clk), .arstn_i(arstn), .vga(vif), .err_clr_i(err_clr), .locked_o(locked),
    .frame_done_o(done), .frame_sum_o(fsum), .frame_cnt_o(fcnt), .err_o(err), .err_cnt_o(ecnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done) n_done++;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit in_win(int l, int x);
    return l >= VA && l < VA + VV && x >= HA && x < HA + HV;
  endfunction
  task automatic check_row(input row_t r);
    chk("locked", locked, r.locked);
    chk("frame_done", done, r.done);
    if (r.done) begin
      exp_fsum = prev_sum;
      exp_ndone++;
    end
    chk("frame_sum", fsum, exp_fsum);
    chk("frame_cnt", fcnt, r.cnt);
    chk("err", err, r.err);
    chk("err_cnt", ecnt, r.ec);
  endtask
  task automatic run_frame(input row_t r, input int nlines);
    logic [23:0] s;
    int len, vsl;
    s = '0;
    for (int l = 0; l < VT; l++)
      for (int x = 0; x < HT; x++) begin
        pix[l][x] = r.kind == K_WHITE ? 12'hFFF :
                    r.kind == K_BLANK ? (in_win(l, x) ? 12'h000 : 12'hFFF) :
                    r.kind == K_DOT   ? ((l == VA && x == HA) ? 12'hABC : 12'h000) :
                    r.kind == K_EARLY ? ((l == VA && x == HA - 1) ? 12'hABC : 12'h000) :
                    12'($urandom_range(0, 4095));
        if (in_win(l, x)) s = s + 24'(pix[l][x]);
      end
    vsl = r.kind == K_VSW ? VS + 1 : VS;
    for (int l = 0; l < nlines; l++) begin
      len = (r.kind == K_LONG && l == 5) ? HT + 1 : HT;
      for (int x = 0; x < len; x++)
        for (int c = 0; c < CF; c++) begin
          {vif.r, vif.g, vif.b} = x < HT ? pix[l][x] : 12'h000;
          vif.hs  = x >= HS;
          vif.vs  = l >= vsl;
          err_clr = l == r.clr_line && x == 0 && c == 0;
          tick();
          if (l == 0 && x == 0 && c == 0) check_row(r);
          if (l == 0 && x == 0 && c == 1) chk("done_width", done, 0);
          if (l == r.clr_line && x == 0 && c == 0) begin
            chk("clr_err", err, r.kind == K_VSW);
            chk("clr_err_cnt", ecnt, r.kind == K_VSW ? 1 : 0);
            if (r.kind == K_VSW) chk("vsw_unlock", locked, 0);
          end
          if (r.kind == K_LONG && l == 6 && x == 0 && c == 0) begin
            chk("long_unlock", locked, 0);
            chk("long_err", err, 1);
            chk("long_err_cnt", ecnt, r.ec + 1);
          end
        end
    end
    err_clr  = 1'b0;
    prev_sum = s;
  endtask
  initial begin
    row_t rr;
    int n;
    rows[0]  = '{K_WHITE, -1, 1'b0, 1'b0, 1'b0, 0, 0};
    rows[1]  = '{K_WHITE, -1, 1'b1, 1'b0, 1'b0, 0, 0};
    rows[2]  = '{K_WHITE, -1, 1'b1, 1'b1, 1'b0, 1, 0};
    rows[3]  = '{K_BLANK, -1, 1'b1, 1'b1, 1'b0, 2, 0};
    rows[4]  = '{K_DOT,   -1, 1'b1, 1'b1, 1'b0, 3, 0};
    rows[5]  = '{K_EARLY, -1, 1'b1, 1'b1, 1'b0, 4, 0};
    rows[6]  = '{K_RAND,  -1, 1'b1, 1'b1, 1'b0, 5, 0};
    rows[7]  = '{K_LONG,  -1, 1'b1, 1'b1, 1'b0, 6, 0};
    rows[8]  = '{K_WHITE, -1, 1'b0, 1'b0, 1'b1, 6, 1};
    rows[9]  = '{K_WHITE, -1, 1'b1, 1'b0, 1'b1, 6, 1};
    rows[10] = '{K_VSW, VS + 1, 1'b1, 1'b1, 1'b1, 7, 1};
    rows[11] = '{K_WHITE,  5, 1'b0, 1'b0, 1'b1, 7, 1};
    rows[12] = '{K_WHITE, -1, 1'b1, 1'b0, 1'b0, 7, 0};
    rows[13] = '{K_RAND,  -1, 1'b1, 1'b1, 1'b0, 8, 0};
    {vif.r, vif.g, vif.b} = 12'h000;
    vif.hs = 1'b1;
    vif.vs = 1'b1;
    repeat (3) tick();
    chk("rst_locked", locked, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", fsum, 0);
    chk("rst_cnt", fcnt, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", ecnt, 0);
    arstn = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 14; i++) run_frame(rows[i], VT);
    rr = '{K_WHITE, -1, 1'b1, 1'b1, 1'b0, 9, 0};
    run_frame(rr, 5);
    arstn = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_done", done, 0);
    chk("arst_sum", fsum, 0);
    chk("arst_cnt", fcnt, 0);
    chk("arst_err", err, 0);
    chk("arst_err_cnt", ecnt, 0);
    exp_fsum = '0;
    tick();
    arstn = 1'b1;
    tick();
    rr = '{K_WHITE, -1, 1'b0, 1'b0, 1'b0, 0, 0};
    run_frame(rr, VT);
    rr = '{K_WHITE, -1, 1'b1, 1'b0, 1'b0, 0, 0};
    run_frame(rr, VT);
    rr = '{K_WHITE, -1, 1'b1, 1'b1, 1'b0, 1, 0};
    run_frame(rr, VT);
    n = 0;
    while (locked && n < 4 * CF * HT) begin
      tick();
      n++;
    end
    chk("static_unlock", locked, 0);
    chk("static_err", err, 1);
    chk("static_err_cnt", ecnt, 1);
    for (int i = 0; i < 5; i++) begin
      rr = '{K_RAND, -1, i > 0, i > 1, 1'b1, 1 + (i > 1 ? i - 1 : 0), 1};
      run_frame(rr, VT);
    end
    rr = '{K_WHITE, -1, 1'b1, 1'b1, 1'b1, 5, 1};
    run_frame(rr, 1);
    chk("done_pulses", n_done, exp_ndone);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
